hs_wrr_pkt_arbiter: RTL and testbench

- Weighted round-robin, packet-locked arbiter for valid/ready handshake channels, such as AXI AW/W/AR muxing in the interconnect.
- Shares one downstream channel among REQ_NUM upstream requesters.
- Each requester receives up to weight_cfg[i] packets per round before the grant pointer moves on.
- The grant locks from the first beat to the last beat of a packet.

---
 rtl/hs_wrr_pkt_arbiter.sv | 133 +++++++++++++
 tb/tb_hs_wrr_pkt_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hs_wrr_pkt_arbiter.sv
// Weighted round-robin, packet-locked arbiter for valid/ready channels.
// A requester can win only while it has credit left. When every valid
// requester is out of credit, all credits reload from weight_cfg.
// The grant is held from the first beat to the last beat of a packet.

module hs_wrr_credit #(
  parameter int WEIGHT_WD = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reload,
  input  logic [WEIGHT_WD-1:0] weight,
  input  logic                 dec,
  output logic [WEIGHT_WD-1:0] credit
);
  // per-lane credit: reload to max(weight,1), decrement on packet end, never below 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      credit <= '0;
    else if (reload)                credit <= (weight == '0) ? WEIGHT_WD'(1) : weight;
    else if (dec && credit != '0)   credit <= credit - WEIGHT_WD'(1);
  end
endmodule

module hs_wrr_pkt_arbiter #(
  parameter int REQ_NUM   = 4,
  parameter int DATA_WD   = 8,
  parameter int WEIGHT_WD = 4,
  parameter int USE_LAST  = 1,
  localparam int IDX_WD   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [REQ_NUM-1:0]           valid_in,
  input  logic [REQ_NUM*DATA_WD-1:0]   payload_in,
  input  logic [REQ_NUM-1:0]           last_in,
  output logic [REQ_NUM-1:0]           ready_in,
  input  logic [REQ_NUM*WEIGHT_WD-1:0] weight_cfg,
  output logic                         valid_out,
  output logic [DATA_WD-1:0]           payload_out,
  output logic                         last_out,
  output logic [IDX_WD-1:0]            grant_id,
  input  logic                         ready_out
);
  typedef enum logic {IDLE, LOCK} state_t;

  state_t                             state, state_nxt;
  logic [IDX_WD-1:0]                  ptr, sel_idx, grant_nxt;
  logic                               sel_found, reload_all, xfer, pkt_end;
  logic [REQ_NUM-1:0]                 elig, dec_vec;
  logic [REQ_NUM-1:0][WEIGHT_WD-1:0]  credit, weight_arr;
  logic [REQ_NUM-1:0][DATA_WD-1:0]    payload_arr;

  assign payload_arr = payload_in;
  assign weight_arr  = weight_cfg;

  // per-lane credit counters and eligibility
  for (genvar i = 0; i < REQ_NUM; i++) begin : g_lane
    hs_wrr_credit #(.WEIGHT_WD(WEIGHT_WD)) u_credit (
      .clk    (clk),
      .rstn   (rstn),
      .reload (reload_all),
      .weight (weight_arr[i]),
      .dec    (dec_vec[i]),
      .credit (credit[i])
    );
    assign elig[i] = valid_in[i] && (credit[i] != '0);
  end

  // rotating priority search: first eligible requester starting at ptr
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % REQ_NUM;
      if (elig[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WD'(idx);
      end
    end
  end

  // handshake and packet-end decode for the locked requester
  always_comb begin
    grant_nxt  = (grant_id == IDX_WD'(REQ_NUM - 1)) ? '0 : grant_id + IDX_WD'(1);
    reload_all = (state == IDLE) && (|valid_in) && !sel_found;
    xfer       = (state == LOCK) && valid_in[grant_id] && ready_out;
    pkt_end    = xfer && ((USE_LAST == 0) || last_in[grant_id]);
    for (int i = 0; i < REQ_NUM; i++)
      dec_vec[i] = pkt_end && (grant_id == IDX_WD'(i));
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: grant when someone is eligible, release on packet end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = LOCK;
      LOCK:    if (pkt_end)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant index and round-robin pointer; pointer moves past g only once its credit runs out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      if (state == IDLE && sel_found) grant_id <= sel_idx;
      if (pkt_end) ptr <= (credit[grant_id] <= WEIGHT_WD'(1)) ? grant_nxt : grant_id;
    end
  end

  // output mux: combinational pass-through of the locked requester, quiet in IDLE
  always_comb begin
    valid_out   = 1'b0;
    last_out    = 1'b0;
    ready_in    = '0;
    payload_out = payload_arr[grant_id];
    if (state == LOCK) begin
      valid_out          = valid_in[grant_id];
      last_out           = last_in[grant_id];
      ready_in[grant_id] = ready_out;
    end
  end
endmodule

// File: tb/tb_hs_wrr_pkt_arbiter.sv
// Bench for hs_wrr_pkt_arbiter. A packet-level WRR model predicts the order
// of beats (and, in timed phases, the cycle of each beat). A separate monitor
// pops those predictions whenever the DUT hands a beat downstream.
module tb_hs_wrr_pkt_arbiter;
  localparam int N = 4, DW = 8, WW = 4;

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { int id; logic [DW-1:0] data; logic last; int cyc; } exp_t;

  logic            clk = 1'b0, rstn = 1'b0;
  logic [N-1:0]    valid_in, last_in, ready_in;
  logic [N*DW-1:0] payload_in;
  logic [N*WW-1:0] weight_cfg;
  logic            valid_out, last_out, ready_out;
  logic [DW-1:0]   payload_out;
  logic [1:0]      grant_id;

  hs_wrr_pkt_arbiter #(.REQ_NUM(N), .DATA_WD(DW), .WEIGHT_WD(WW), .USE_LAST(1)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in),
    .last_in(last_in), .ready_in(ready_in), .weight_cfg(weight_cfg),
    .valid_out(valid_out), .payload_out(payload_out), .last_out(last_out),
    .grant_id(grant_id), .ready_out(ready_out)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    vectors = 0, miscompares = 0;
  beat_t drv_q[N][$];
  bit    first[N], acc[N];
  bit    timed = 1'b0, t0_pend = 1'b0;
  int    t0 = 0;
  exp_t  exp_q[$];
  int    m_w[N], m_cr[N], m_ptr = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // monitor: every downstream beat must be the next predicted one
  always begin
    @(negedge clk); #4;
    if (rstn && valid_out && ready_out) begin
      exp_t e; int rel; logic [N-1:0] rdy_exp;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", $sformatf("got id=%0d data=%h, required no beat", grant_id, payload_out));
      end else begin
        e = exp_q.pop_front();
        rel = cyc - t0;
        rdy_exp = N'(1) << e.id;
        chk(grant_id == 2'(e.id) && payload_out == e.data && last_out == e.last &&
            ready_in == rdy_exp && (e.cyc < 0 || rel == e.cyc), "beat",
            $sformatf("got id=%0d data=%h last=%b rdy=%b cyc=%0d, required id=%0d data=%h last=%b rdy=%b cyc=%0d",
                      grant_id, payload_out, last_out, ready_in, rel, e.id, e.data, e.last, rdy_exp, e.cyc));
      end
    end
  end

  // one clock of stimulus: retire accepted beats, drive the next ones
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (acc[i] && drv_q[i].size() > 0) begin
        beat_t b;
        b = drv_q[i].pop_front();
        first[i] = b.last;
      end
    if (t0_pend) begin t0 = cyc; t0_pend = 1'b0; end
    ready_out = timed ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < N; i++) begin
      if (drv_q[i].size() > 0) begin
        // valid may drop only mid-packet, i.e. while this requester is locked
        valid_in[i] = first[i] || timed || ($urandom_range(0, 3) != 0);
        payload_in[i*DW +: DW] = drv_q[i][0].data;
        last_in[i] = drv_q[i][0].last;
      end else begin
        valid_in[i] = 1'b0;
        payload_in[i*DW +: DW] = DW'($urandom);
        last_in[i] = 1'($urandom_range(0, 1));
      end
    end
    #4;
    for (int i = 0; i < N; i++) acc[i] = rstn && valid_in[i] && ready_in[i];
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    int w[N];
    w = '{a, b, c, d};
    for (int i = 0; i < N; i++) begin
      weight_cfg[i*WW +: WW] = WW'(w[i]);
      m_w[i] = w[i];
    end
  endtask

  // build packets, predict the WRR service order at packet level, queue stimulus
  task automatic start_phase(input logic [N-1:0] mask, input int np_lo, input int np_hi,
                             input int ln_lo, input int ln_hi, input bit tmd);
    beat_t pk[N][$];
    int    plen[N][$];
    int    rem[N], pos[N];
    int    t;
    t = 0;
    timed = tmd;
    for (int i = 0; i < N; i++) begin
      rem[i] = mask[i] ? int'($urandom_range(np_lo, np_hi)) : 0;
      pos[i] = 0;
      for (int p = 0; p < rem[i]; p++) begin
        int len;
        len = $urandom_range(ln_lo, ln_hi);
        plen[i].push_back(len);
        for (int b = 0; b < len; b++) begin
          beat_t bt;
          bt.data = DW'($urandom);
          bt.last = (b == len - 1);
          pk[i].push_back(bt);
        end
      end
    end
    while (1) begin
      int j, len;
      bit any, el;
      j = -1; any = 1'b0; el = 1'b0;
      for (int i = 0; i < N; i++)
        if (rem[i] > 0) begin any = 1'b1; if (m_cr[i] > 0) el = 1'b1; end
      if (!any) break;
      if (!el) begin
        for (int i = 0; i < N; i++) m_cr[i] = (m_w[i] == 0) ? 1 : m_w[i];
        t++;
      end
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (rem[c] > 0 && m_cr[c] > 0) begin j = c; break; end
      end
      len = plen[j].pop_front();
      for (int b = 0; b < len; b++) begin
        exp_t e;
        e.id = j;
        e.data = pk[j][pos[j] + b].data;
        e.last = pk[j][pos[j] + b].last;
        e.cyc = tmd ? t + 1 + b : -1;
        exp_q.push_back(e);
      end
      pos[j] += len;
      t += len + 1;
      rem[j]--;
      m_cr[j]--;
      m_ptr = (m_cr[j] == 0) ? (j + 1) % N : j;
    end
    for (int i = 0; i < N; i++)
      foreach (pk[i][b]) drv_q[i].push_back(pk[i][b]);
    t0_pend = 1'b1;
  endtask

  task automatic drain(input string name);
    int k, left;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin step(); k++; end
    chk(exp_q.size() == 0, {name, "_drain"},
        $sformatf("got %0d beats outstanding after %0d cycles, required 0", exp_q.size(), k));
    exp_q.delete();
    repeat (3) step();
    left = 0;
    for (int i = 0; i < N; i++) left += drv_q[i].size();
    chk(!valid_out && ready_in == '0 && left == 0, {name, "_idle"},
        $sformatf("got valid_out=%b ready_in=%b pending_beats=%0d, required 0/0000/0", valid_out, ready_in, left));
    for (int i = 0; i < N; i++) begin drv_q[i].delete(); first[i] = 1'b1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_in = '0; last_in = '0; ready_out = 1'b0;
    payload_in = 32'hA5C3_5A3C;
    weight_cfg = '0;
    for (int i = 0; i < N; i++) begin first[i] = 1'b1; acc[i] = 1'b0; m_cr[i] = 0; m_w[i] = 0; end
    #3;
    chk(!valid_out && ready_in == '0 && grant_id == 2'd0 && !last_out && payload_out == payload_in[DW-1:0],
        "reset_state", $sformatf("got valid=%b ready_in=%b gid=%0d last=%b pay=%h, required 0/0000/0/0/%h",
                                 valid_out, ready_in, grant_id, last_out, payload_out, payload_in[DW-1:0]));
    @(negedge clk); #2 rstn = 1'b1;
    repeat (2) step();

    set_w(1, 1, 1, 1); start_phase(4'b1111, 3, 3, 1, 1, 1'b1); drain("equal_weights");
    set_w(3, 1, 1, 1); start_phase(4'b1111, 3, 3, 1, 1, 1'b1); drain("weight3");
    set_w(1, 1, 1, 1); start_phase(4'b0101, 1, 2, 4, 4, 1'b1); drain("multibeat_lock");
    set_w(2, 0, 2, 2); start_phase(4'b0010, 3, 3, 1, 1, 1'b1); drain("weight0");
    for (int p = 0; p < 12; p++) begin
      set_w($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      start_phase(4'($urandom_range(1, 15)), 0, 4, 1, 4, 1'b0);
      drain("random");
    end

    // reset while requester 2 holds the lock mid-packet
    set_w(1, 1, 1, 1); start_phase(4'b0100, 1, 1, 6, 6, 1'b1);
    begin
      int k;
      k = 0;
      step();
      while (!valid_out && k < 20) begin step(); k++; end
      chk(valid_out && grant_id == 2'd2, "lock_reached",
          $sformatf("got valid_out=%b gid=%0d, required 1/2", valid_out, grant_id));
    end
    @(negedge clk); #2 rstn = 1'b0; #1;
    chk(!valid_out && ready_in == '0 && grant_id == 2'd0, "async_reset",
        $sformatf("got valid=%b ready_in=%b gid=%0d, required 0/0000/0", valid_out, ready_in, grant_id));
    for (int i = 0; i < N; i++) begin drv_q[i].delete(); first[i] = 1'b1; acc[i] = 1'b0; m_cr[i] = 0; end
    m_ptr = 0;
    exp_q.delete();
    repeat (2) step();
    @(negedge clk); #2 rstn = 1'b1;
    repeat (2) step();
    set_w(1, 2, 1, 1); start_phase(4'b1111, 2, 2, 1, 3, 1'b1); drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
